tl_phase_timer: RTL and testbench

//  Per-phase green/amber duration store plus the countdown timer that paces TrafficLight_CU.
//  CU requests a phase duration with load and receives a one-cycle expire when the time runs out.

---
 rtl/tl_pkg.sv | 18 +
 rtl/tl_key_pulse.sv | 30 +++
 rtl/tl_phase_timer.sv | 123 ++++++++++++
 tb/tb_tl_phase_timer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared traffic-light constants and the edit-mode state type.
// Used by tl_phase_timer and TrafficLight_CU.
package tl_pkg;

    localparam int NUM_PHASES = 4;
    localparam int PH_W       = 2;
    localparam int T_W        = 8;

    localparam logic [T_W-1:0] T_MIN = T_W'(1);
    localparam logic [T_W-1:0] T_MAX = T_W'(99);
    localparam logic [T_W-1:0] DEF_T = T_W'(10);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EDIT = 1'b1
    } edit_state_e;

endpackage

// File: rtl/tl_key_pulse.sv
// Two-flop synchroniser for a raw board input plus a rising-edge detector.
// level is the synchronised input; pulse is high for one cycle per rise.
module tl_key_pulse (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign pulse = sync & ~prev;

endmodule

// File: rtl/tl_phase_timer.sv
// Per-phase duration table, board edit mode and the one-second countdown
// that paces the traffic-light controller.
module tl_phase_timer
    import tl_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            modify,
    input  logic            timeup,
    input  logic            timedown,
    input  logic            phase_valid,
    input  logic            load,
    input  logic [PH_W-1:0] load_phase,
    output logic            expire,
    output logic [T_W-1:0]  remaining,
    output logic            cfg_busy,
    output logic [PH_W-1:0] edit_phase,
    output logic [T_W-1:0]  edit_value
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Handshake: load is a valid-only strobe with no ready; it is accepted on
    // every edge it is high, in either edit state, and always wins over a tick.

    logic modify_lvl, modify_rise;
    logic up_lvl, up_rise;
    logic dn_lvl, dn_rise;
    logic pv_lvl, pv_rise;
    logic unused_key;

    tl_key_pulse u_sync_modify (.clk(clk), .rst(rst), .raw(modify),
                                .level(modify_lvl), .pulse(modify_rise));
    tl_key_pulse u_sync_up     (.clk(clk), .rst(rst), .raw(timeup),
                                .level(up_lvl), .pulse(up_rise));
    tl_key_pulse u_sync_down   (.clk(clk), .rst(rst), .raw(timedown),
                                .level(dn_lvl), .pulse(dn_rise));
    tl_key_pulse u_sync_pv     (.clk(clk), .rst(rst), .raw(phase_valid),
                                .level(pv_lvl), .pulse(pv_rise));

    assign unused_key = ^{modify_rise, up_lvl, dn_lvl, pv_lvl};

    edit_state_e state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (modify_lvl)  state_nxt = ST_EDIT;
            ST_EDIT: if (!modify_lvl) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cfg_busy = (state == ST_EDIT);

    logic [T_W-1:0]  dur_tbl [NUM_PHASES];
    logic [PH_W-1:0] next_phase;
    logic            enter_edit;

    assign enter_edit = (state == ST_IDLE) && modify_lvl;
    assign next_phase = (edit_phase == PH_W'(NUM_PHASES - 1)) ? '0 : edit_phase + 1'b1;

    // A commit takes priority over a step arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHASES; i++) dur_tbl[i] <= DEF_T;
            edit_phase <= '0;
            edit_value <= DEF_T;
        end else if (enter_edit) begin
            edit_phase <= '0;
            edit_value <= dur_tbl[0];
        end else if (state == ST_EDIT) begin
            if (pv_rise) begin
                dur_tbl[edit_phase] <= edit_value;
                edit_phase          <= next_phase;
                edit_value          <= (next_phase == edit_phase) ? edit_value
                                                                  : dur_tbl[next_phase];
            end else if (up_rise && !dn_rise) begin
                if (edit_value < T_MAX) edit_value <= edit_value + 1'b1;
            end else if (dn_rise && !up_rise) begin
                if (edit_value > T_MIN) edit_value <= edit_value - 1'b1;
            end
        end
    end

    logic [PH_W-1:0]  load_idx;
    logic [CNT_W-1:0] tick_cnt;
    logic             run;
    logic             tick;

    assign load_idx = ({1'b0, load_phase} >= (PH_W+1)'(NUM_PHASES)) ? PH_W'(NUM_PHASES - 1)
                                                                    : load_phase;
    assign run  = (state == ST_IDLE) && (remaining != '0);
    assign tick = run && (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            tick_cnt  <= '0;
            expire    <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (load) begin
                remaining <= dur_tbl[load_idx];
                tick_cnt  <= '0;
            end else if (tick) begin
                tick_cnt  <= '0;
                remaining <= remaining - 1'b1;
                expire    <= (remaining == T_W'(1));
            end else if (run) begin
                tick_cnt  <= tick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tl_phase_timer.sv
// Directed bench for tl_phase_timer with a fast one-second tick (4 clocks).
module tb_tl_phase_timer;

    localparam int K_UP    = 0;
    localparam int K_DN    = 1;
    localparam int K_PV    = 2;
    localparam int K_BOTH  = 3;
    localparam int K_ENTER = 4;
    localparam int K_EXIT  = 5;
    localparam int K_LOAD  = 6;

    typedef struct {
        int key;
        int arg;
        int exp_value;
        int exp_phase;
        int exp_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       modify = 1'b0;
    logic       timeup = 1'b0;
    logic       timedown = 1'b0;
    logic       phase_valid = 1'b0;
    logic       load = 1'b0;
    logic [1:0] load_phase = 2'd0;
    logic       expire;
    logic [7:0] remaining;
    logic       cfg_busy;
    logic [1:0] edit_phase;
    logic [7:0] edit_value;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    vec_t vecs[$];

    tl_phase_timer #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .modify(modify), .timeup(timeup),
        .timedown(timedown), .phase_valid(phase_valid), .load(load),
        .load_phase(load_phase), .expire(expire), .remaining(remaining),
        .cfg_busy(cfg_busy), .edit_phase(edit_phase), .edit_value(edit_value)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic do_load(input int ph);
        load = 1'b1;
        load_phase = 2'(ph);
        step(1);
        load = 1'b0;
    endtask

    task automatic apply_key(input int key, input int arg);
        case (key)
            K_UP:    timeup = 1'b1;
            K_DN:    timedown = 1'b1;
            K_PV:    phase_valid = 1'b1;
            K_BOTH:  begin timeup = 1'b1; timedown = 1'b1; end
            K_ENTER: modify = 1'b1;
            K_EXIT:  modify = 1'b0;
            default: ;
        endcase
        if (key == K_LOAD) begin
            do_load(arg);
        end else begin
            step(4);
            timeup = 1'b0;
            timedown = 1'b0;
            phase_valid = 1'b0;
            step(3);
        end
    endtask

    function automatic void add(input int key, input int arg, input int v,
                                input int ph, input int busy);
        vec_t r;
        r.key = key; r.arg = arg; r.exp_value = v; r.exp_phase = ph; r.exp_busy = busy;
        vecs.push_back(r);
    endfunction

    initial begin
        int pulses;
        int pulse_at;
        int got_at;

        // edit / commit / saturation / wrap vectors
        add(K_ENTER, 0, 10, 0, 1);
        add(K_UP, 0, 11, 0, 1);
        add(K_UP, 0, 12, 0, 1);
        add(K_UP, 0, 13, 0, 1);
        add(K_PV, 0, 10, 1, 1);
        for (int i = 0; i < 12; i++) add(K_DN, 0, (9 - i < 1) ? 1 : 9 - i, 1, 1);
        for (int i = 0; i < 120; i++) add(K_UP, 0, (2 + i > 99) ? 99 : 2 + i, 1, 1);
        add(K_BOTH, 0, 99, 1, 1);
        add(K_EXIT, 0, 0, 0, 0);
        add(K_LOAD, 0, 13, 0, 0);
        add(K_LOAD, 1, 10, 0, 0);
        add(K_ENTER, 0, 13, 0, 1);
        add(K_PV, 0, 10, 1, 1);
        add(K_PV, 0, 10, 2, 1);
        add(K_PV, 0, 10, 3, 1);
        add(K_PV, 0, 13, 0, 1);
        add(K_EXIT, 0, 0, 0, 0);
        add(K_LOAD, 0, 13, 0, 0);
        add(K_LOAD, 1, 10, 0, 0);
        add(K_LOAD, 3, 10, 0, 0);

        // reset state
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_remaining", int'(remaining), 0);
        check("rst_expire", int'(expire), 0);
        check("rst_busy", int'(cfg_busy), 0);
        check("rst_edit_phase", int'(edit_phase), 0);
        check("rst_edit_value", int'(edit_value), 10);

        // first countdown: phase 2, 10 s, 4 clocks per second
        for (int c = 1; c <= 45; c++) exp_q.push_back(8'((c / 4 > 10) ? 0 : 10 - c / 4));
        do_load(2);
        check("load_remaining", int'(remaining), 10);
        pulses = 0;
        pulse_at = -1;
        for (int c = 1; c <= 45; c++) begin
            step(1);
            check($sformatf("cd_remaining_c%0d", c), int'(remaining), int'(exp_q.pop_front()));
            if (expire) begin
                pulses++;
                pulse_at = c;
            end
        end
        check("cd_expire_count", pulses, 1);
        check("cd_expire_cycle", pulse_at, 40);

        // table-driven edit vectors
        for (int i = 0; i < vecs.size(); i++) begin
            apply_key(vecs[i].key, vecs[i].arg);
            if (vecs[i].key == K_LOAD) begin
                check($sformatf("vec%0d_remaining", i), int'(remaining), vecs[i].exp_value);
            end else begin
                check($sformatf("vec%0d_busy", i), int'(cfg_busy), vecs[i].exp_busy);
                if (vecs[i].key != K_EXIT) begin
                    check($sformatf("vec%0d_value", i), int'(edit_value), vecs[i].exp_value);
                    check($sformatf("vec%0d_phase", i), int'(edit_phase), vecs[i].exp_phase);
                end
            end
        end

        // load in the tick cycle at remaining=1: load wins, old countdown never expires
        do_load(1);
        step(39);
        check("pre_load_remaining", int'(remaining), 1);
        pulses = 0;
        load = 1'b1;
        load_phase = 2'd0;
        step(1);
        load = 1'b0;
        check("reload_remaining", int'(remaining), 13);
        if (expire) pulses++;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (expire) pulses++;
        end
        check("reload_no_expire", pulses, 0);
        check("reload_after6", int'(remaining), 12);

        // freeze while editing
        do_load(1);
        step(20);
        check("frz_start", int'(remaining), 5);
        modify = 1'b1;
        step(3);
        check("frz_busy", int'(cfg_busy), 1);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (expire || remaining != 8'd5) pulses++;
        end
        check("frz_held", pulses, 0);
        check("frz_remaining", int'(remaining), 5);
        modify = 1'b0;
        step(3);
        check("frz_exit_busy", int'(cfg_busy), 0);
        check("frz_exit_remaining", int'(remaining), 5);
        pulses = 0;
        got_at = -1;
        for (int c = 1; c <= 30; c++) begin
            step(1);
            check($sformatf("resume_c%0d", c), int'(remaining),
                  ((c + 3) / 4 > 5) ? 0 : 5 - (c + 3) / 4);
            if (expire) begin
                pulses++;
                got_at = c;
            end
        end
        check("resume_expire_count", pulses, 1);
        check("resume_expire_cycle", got_at, 17);

        // reset mid-edit and mid-countdown
        do_load(0);
        step(5);
        modify = 1'b1;
        step(3);
        apply_key(K_UP, 0);
        check("pre_rst_value", int'(edit_value), 14);
        check("pre_rst_busy", int'(cfg_busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_remaining", int'(remaining), 0);
        check("mid_rst_expire", int'(expire), 0);
        check("mid_rst_busy", int'(cfg_busy), 0);
        check("mid_rst_edit_phase", int'(edit_phase), 0);
        check("mid_rst_edit_value", int'(edit_value), 10);
        modify = 1'b0;
        step(2);
        rst = 1'b0;
        step(3);
        check("post_rst_busy", int'(cfg_busy), 0);
        do_load(0);
        check("post_rst_table0", int'(remaining), 10);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
